comm_master_nbyte: RTL and testbench

Parametrised command master that sends a CMD_BYTES-wide command MSB-byte-first through an external UART transmitter, and can optionally collect a RESP_BYTES-wide response from the UART receiver.
- Successor to the fixed 2-byte command sender: adds width generalisation, response collection, a response timeout and stale-RX flushing.
- Sits between the host control logic and the UART; the UART is not instantiated inside this block.

---
 rtl/comm_master_nbyte.sv | 200 ++++++++++++++++++++
 tb/tb_comm_master_nbyte.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/comm_master_nbyte.sv
// -----------------------------------------------------------------------------
// comm_master_nbyte
//
// Command master that drives an external UART. It sends a CMD_BYTES-wide
// command one byte at a time, MSB byte first. It can then optionally collect
// a RESP_BYTES-wide response from the UART receiver. The response is guarded
// by an inter-byte timeout. Any receiver byte that arrives while no response
// is expected is flushed and discarded.
//
// Parameters
//   CMD_BYTES       command bytes per transaction (>=1)
//   RESP_BYTES      response bytes collected when a response is requested (>=1)
//   TIMEOUT_CYCLES  max idle cycles allowed between response bytes (>=2)
//
// Ports
//   clk, rst_n      system clock, async active-low reset
//   cmd_i           command word, sampled when snd_cmd_i is accepted in IDLE
//   snd_cmd_i       start request
//   wait_resp_i     sampled with snd_cmd_i; 1 = collect a response
//   busy_o          high whenever the FSM is not IDLE
//   trmt_o          one-cycle pulse that starts one UART byte transmission
//   tx_data_o       byte being transmitted
//   tx_done_i       UART transmitter byte complete
//   rx_rdy_i        UART receiver byte available
//   rx_data_i       received byte, valid while rx_rdy_i=1
//   clr_rdy_o       clears the receiver's rx_rdy
//   cmd_cmplt_o     one-cycle pulse after the last command byte completes
//   resp_o          assembled response, first received byte in the MSBs
//   resp_vld_o      one-cycle pulse when resp_o holds a complete response
//   timeout_o       one-cycle pulse when a response is aborted
//
// State table
//   IDLE    | waiting for snd_cmd_i
//   SEND    | trmt_o asserted for the current command byte
//   WAIT_TX | byte in flight, waiting for tx_done_i
//   RX      | collecting response bytes under the inter-byte timeout
// -----------------------------------------------------------------------------
module comm_master_nbyte #(
  parameter int CMD_BYTES      = 2,
  parameter int RESP_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*CMD_BYTES-1:0]  cmd_i,
  input  logic                    snd_cmd_i,
  input  logic                    wait_resp_i,
  output logic                    busy_o,
  output logic                    trmt_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_done_i,
  input  logic                    rx_rdy_i,
  input  logic [7:0]              rx_data_i,
  output logic                    clr_rdy_o,
  output logic                    cmd_cmplt_o,
  output logic [8*RESP_BYTES-1:0] resp_o,
  output logic                    resp_vld_o,
  output logic                    timeout_o
);

  localparam int CW  = 8 * CMD_BYTES;
  localparam int RW  = 8 * RESP_BYTES;
  localparam int BCW = (CMD_BYTES  > 1) ? $clog2(CMD_BYTES)  : 1;
  localparam int RCW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(CMD_BYTES - 1);
  localparam logic [RCW-1:0] LAST_RESP = RCW'(RESP_BYTES - 1);
  localparam logic [TW-1:0]  TMO_TC    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_TX = 2'd2,
    RX      = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  shift_q, shift_d;
  logic           wresp_q, wresp_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [RW-1:0]  resp_q, resp_d;
  logic           cmplt_q, cmplt_d;
  logic           vld_q, vld_d;
  logic           tmo_q, tmo_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      wresp_q <= 1'b0;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      resp_q  <= '0;
      cmplt_q <= 1'b0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      wresp_q <= wresp_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      resp_q  <= resp_d;
      cmplt_q <= cmplt_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    wresp_d = wresp_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    resp_d  = resp_q;
    cmplt_d = 1'b0;
    vld_d   = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (snd_cmd_i) begin
          shift_d = cmd_i;
          wresp_d = wait_resp_i;
          bcnt_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        state_d = WAIT_TX;
      end

      WAIT_TX: begin
        if (tx_done_i) begin
          if (bcnt_q == LAST_BYTE) begin
            cmplt_d = 1'b1;
            if (wresp_q) begin
              rcnt_d  = '0;
              tcnt_d  = '0;
              state_d = RX;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q << 8;
            bcnt_d  = bcnt_q + BCW'(1);
            state_d = SEND;
          end
        end
      end

      RX: begin
        // A byte arriving on the terminal-count cycle takes priority.
        if (rx_rdy_i) begin
          resp_d = RW'({resp_q, rx_data_i});
          rcnt_d = rcnt_q + RCW'(1);
          tcnt_d = '0;
          if (rcnt_q == LAST_RESP) begin
            vld_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tcnt_q == TMO_TC) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. clr_rdy follows rx_rdy in every state: a byte seen outside RX is
  // a stale one and gets flushed, and a byte seen in RX is consumed.
  always_comb begin
    busy_o    = (state_q != IDLE);
    trmt_o    = (state_q == SEND);
    tx_data_o = shift_q[CW-1 -: 8];
    clr_rdy_o = rx_rdy_i;
  end

  assign cmd_cmplt_o = cmplt_q;
  assign resp_o      = resp_q;
  assign resp_vld_o  = vld_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_comm_master_nbyte.sv
module tb_comm_master_nbyte;

  localparam int CB = 3;
  localparam int RB = 2;
  localparam int TO = 50;
  localparam int RW = 8 * RB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*CB-1:0] cmd = '0;
  logic            snd_cmd = 1'b0;
  logic            wait_resp = 1'b0;
  logic            busy, trmt, clr_rdy, cmd_cmplt, resp_vld, timeout;
  logic [7:0]      tx_data;
  logic            tx_done = 1'b0;
  logic            rx_rdy = 1'b0;
  logic [7:0]      rx_data = '0;
  logic [RW-1:0]   resp;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] resp_m = '0;

  comm_master_nbyte #(
    .CMD_BYTES(CB), .RESP_BYTES(RB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_i(cmd), .snd_cmd_i(snd_cmd), .wait_resp_i(wait_resp),
    .busy_o(busy), .trmt_o(trmt), .tx_data_o(tx_data),
    .tx_done_i(tx_done), .rx_rdy_i(rx_rdy), .rx_data_i(rx_data),
    .clr_rdy_o(clr_rdy), .cmd_cmplt_o(cmd_cmplt),
    .resp_o(resp), .resp_vld_o(resp_vld), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    snd_cmd = 1'b0;
    tx_done = 1'b0;
    rx_rdy  = 1'b0;
  endtask

  // One transaction acting as the UART: answers each trmt with tx_done after a
  // random delay, then optionally feeds response bytes.
  task automatic txn(input logic [8*CB-1:0] c, input bit wr, input int n_rx,
                     input bit stale, input bit resend, input bit do_rst,
                     input bit rnd_rx, input logic [RW-1:0] rxv);
    logic [7:0] b;
    logic [7:0] rb;
    int d;
    int g;
    step();
    cmd = c; wait_resp = wr; snd_cmd = 1'b1;
    step();
    chk("busy_start", busy, 1);
    for (int i = 0; i < CB; i++) begin
      b = 8'(c >> (8 * (CB - 1 - i)));
      chk("trmt", trmt, 1);
      chk("tx_data", tx_data, b);
      chk("cmplt_early", cmd_cmplt, 0);
      d = $urandom_range(1, 8);
      for (int w = 0; w < d; w++) begin
        step();
        chk("trmt_hold", trmt, 0);
        chk("tx_hold", tx_data, b);
        chk("busy_wait", busy, 1);
        if (do_rst && i == 1) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_trmt", trmt, 0);
          chk("rst_txdata", tx_data, 0);
          chk("rst_resp", resp, 0);
          chk("rst_cmplt", cmd_cmplt, 0);
          resp_m = '0;
          repeat (3) begin
            step();
            chk("rst_hold_cmplt", cmd_cmplt, 0);
            chk("rst_hold_busy", busy, 0);
          end
          rst_n = 1'b1;
          return;
        end
        if (w == 0 && stale) begin
          rx_data = 8'hFF; rx_rdy = 1'b1;
          #1 chk("clr_stale", clr_rdy, 1);
        end
        if (w == 0 && resend) begin
          cmd = ~c; wait_resp = ~wr; snd_cmd = 1'b1;
        end
        if (w == d - 1) tx_done = 1'b1;
      end
      step();
    end
    chk("cmd_cmplt", cmd_cmplt, 1);
    chk("busy_cmplt", busy, wr);
    chk("trmt_cmplt", trmt, 0);
    if (!wr) begin
      step();
      chk("cmplt_once", cmd_cmplt, 0);
      chk("no_vld", resp_vld, 0);
      chk("resp_keep", resp, resp_m);
      return;
    end
    for (int k = 0; k < n_rx; k++) begin
      g = $urandom_range(0, 12);
      for (int j = 0; j < g; j++) begin
        step();
        chk("rx_busy", busy, 1);
        chk("rx_novld", resp_vld, 0);
        chk("rx_notmo", timeout, 0);
        if ($urandom_range(0, 3) == 0) tx_done = 1'b1;
      end
      rb = rnd_rx ? 8'($urandom) : 8'(rxv >> (8 * (RB - 1 - k)));
      rx_data = rb; rx_rdy = 1'b1;
      #1 chk("clr_rx", clr_rdy, 1);
      resp_m = RW'((resp_m << 8) | RW'(rb));
      step();
      if (k == RB - 1) begin
        chk("resp_vld", resp_vld, 1);
        chk("resp", resp, resp_m);
        chk("busy_done", busy, 0);
      end else begin
        chk("vld_partial", resp_vld, 0);
        chk("busy_partial", busy, 1);
      end
    end
    if (n_rx < RB) begin
      for (int j = 1; j < TO; j++) begin
        step();
        chk("tmo_early", timeout, 0);
        chk("tmo_busy", busy, 1);
      end
      step();
      chk("timeout", timeout, 1);
      chk("tmo_novld", resp_vld, 0);
      chk("tmo_busy_fall", busy, 0);
      chk("tmo_resp_partial", resp, resp_m);
      step();
      chk("tmo_once", timeout, 0);
    end else begin
      step();
      chk("vld_once", resp_vld, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8*CB-1:0] c;
    bit wr;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_trmt", trmt, 0);
    chk("reset_txdata", tx_data, 0);
    chk("reset_resp", resp, 0);
    chk("reset_cmplt", cmd_cmplt, 0);
    chk("reset_vld", resp_vld, 0);
    chk("reset_tmo", timeout, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    txn(24'hA55A3C, 0, 0, 0, 0, 0, 0, '0);
    txn(24'h123456, 1, 2, 0, 0, 0, 0, 16'hC37E);
    chk("resp_c37e", resp, 16'hC37E);
    txn(24'h0F1E2D, 1, 1, 0, 0, 0, 0, 16'h9900);
    txn(24'hBEEF01, 1, 2, 1, 0, 0, 0, 16'h1234);
    chk("resp_no_ff", resp, 16'h1234);
    txn(24'h55AA77, 0, 0, 0, 1, 0, 0, '0);
    txn(24'hDEAD42, 0, 0, 0, 0, 1, 0, '0);
    txn(24'h13579B, 1, 2, 0, 0, 0, 0, 16'hA1B2);
    txn(24'h2468AC, 1, 0, 0, 0, 0, 0, '0);

    for (int t = 0; t < 25; t++) begin
      c  = (8*CB)'($urandom);
      wr = 1'($urandom_range(0, 1));
      txn(c, wr, $urandom_range(0, RB), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'(t % 9 == 4), 1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
